// File: rtl/cam_fill_ctrl.sv
// cam_fill_ctrl: miss-fill and flush controller driving the cam write port.
// Fetches a missing line over req/ack, then writes it to a victim entry.
module cam_fill_ctrl #(
  parameter int BITS = 8,
  parameter int TAG_SZ = 8,
  parameter int WORDS = 8,
  localparam int ADDR_LEFT = $clog2(WORDS) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  input  logic [TAG_SZ-1:0]   miss_tag,
  output logic                miss_ready,
  output logic                mem_req,
  output logic [TAG_SZ-1:0]   mem_tag,
  input  logic                mem_ack,
  input  logic [BITS-1:0]     mem_data,
  input  logic                flush,
  output logic                write_,
  output logic [ADDR_LEFT:0]  w_addr,
  output logic [BITS-1:0]     wdata,
  output logic [TAG_SZ-1:0]   new_tag,
  output logic                new_valid,
  output logic                busy,
  output logic                fill_done
);

  typedef logic [ADDR_LEFT:0] addr_t;
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WRITE,
    FLUSH
  } state_t;

  localparam addr_t LAST = addr_t'(WORDS - 1);

  state_t            state;
  state_t            state_n;

  logic [WORDS-1:0]  vmap;
  addr_t             rr;
  addr_t             rr_inc;
  addr_t             vict_q;
  addr_t             vict_free;
  logic              has_free;
  logic              pend;
  logic              accept;
  logic              flush_last;

  logic              write_n;
  addr_t             w_addr_n;
  logic [BITS-1:0]   wdata_n;
  logic [TAG_SZ-1:0] new_tag_n;
  logic              new_valid_n;
  logic              mem_req_n;
  logic [TAG_SZ-1:0] mem_tag_n;
  logic              busy_n;
  logic              fill_done_n;

  assign miss_ready = (state == IDLE) && !flush && !pend;
  assign accept     = miss_valid && miss_ready;
  assign flush_last = (state == FLUSH) && (w_addr == LAST);
  assign rr_inc     = (rr == LAST) ? '0 : rr + 1'b1;

  // Lowest-index free entry; has_free low when the cam is full.
  always_comb begin
    vict_free = '0;
    has_free  = 1'b0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!vmap[i]) begin
        vict_free = addr_t'(i);
        has_free  = 1'b1;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      write_    <= 1'b1;
      w_addr    <= '0;
      wdata     <= '0;
      new_tag   <= '0;
      new_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_tag   <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_n;
      write_    <= write_n;
      w_addr    <= w_addr_n;
      wdata     <= wdata_n;
      new_tag   <= new_tag_n;
      new_valid <= new_valid_n;
      mem_req   <= mem_req_n;
      mem_tag   <= mem_tag_n;
      busy      <= busy_n;
      fill_done <= fill_done_n;
    end
  end

  // Next-state decode; flush has priority over a miss in IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (flush || pend)
          state_n = FLUSH;
        else if (miss_valid)
          state_n = REQ;
      end
      REQ: begin
        if (mem_ack)
          state_n = WRITE;
      end
      WRITE: state_n = IDLE;
      FLUSH: begin
        if (w_addr == LAST)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    write_n     = 1'b1;
    w_addr_n    = w_addr;
    wdata_n     = wdata;
    new_tag_n   = new_tag;
    new_valid_n = new_valid;
    mem_req_n   = mem_req;
    mem_tag_n   = mem_tag;
    fill_done_n = 1'b0;
    busy_n      = (state_n != IDLE);
    unique case (state)
      IDLE: begin
        if (flush || pend) begin
          write_n     = 1'b0;
          w_addr_n    = '0;
          wdata_n     = '0;
          new_tag_n   = '0;
          new_valid_n = 1'b0;
        end else if (accept) begin
          mem_req_n = 1'b1;
          mem_tag_n = miss_tag;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_n   = 1'b0;
          write_n     = 1'b0;
          w_addr_n    = vict_q;
          wdata_n     = mem_data;
          new_tag_n   = mem_tag;
          new_valid_n = 1'b1;
          fill_done_n = 1'b1;
        end
      end
      WRITE: begin
        fill_done_n = 1'b0;
      end
      FLUSH: begin
        if (w_addr != LAST) begin
          write_n  = 1'b0;
          w_addr_n = w_addr + 1'b1;
        end
      end
      default: begin
        write_n = 1'b1;
      end
    endcase
  end

  // Victim latch, valid map, round-robin pointer and pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      vmap   <= '0;
      rr     <= '0;
      vict_q <= '0;
      pend   <= 1'b0;
    end else begin
      if (accept) begin
        if (has_free) begin
          vict_q <= vict_free;
        end else begin
          vict_q <= rr;
          rr     <= rr_inc;
        end
      end
      if (flush && ((state == REQ) || (state == WRITE)))
        pend <= 1'b1;
      if (state == WRITE)
        vmap[vict_q] <= 1'b1;
      if (flush_last) begin
        vmap <= '0;
        rr   <= '0;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// tb_cam_fill_ctrl: randomized and directed bench for cam_fill_ctrl.
// Victim choice is predicted from a valid-bit array and a pointer.
module tb_cam_fill_ctrl;

  localparam int WORDS = 8;

  logic       clk;
  logic       rst;
  logic       miss_valid;
  logic [7:0] miss_tag;
  logic       miss_ready;
  logic       mem_req;
  logic [7:0] mem_tag;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       flush;
  logic       write_;
  logic [2:0] w_addr;
  logic [7:0] wdata;
  logic [7:0] new_tag;
  logic       new_valid;
  logic       busy;
  logic       fill_done;

  int n_checks = 0;
  int n_err = 0;

  bit vm[WORDS];
  int rr;

  cam_fill_ctrl #(
    .BITS(8),
    .TAG_SZ(8),
    .WORDS(WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .miss_valid(miss_valid),
    .miss_tag(miss_tag),
    .miss_ready(miss_ready),
    .mem_req(mem_req),
    .mem_tag(mem_tag),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .flush(flush),
    .write_(write_),
    .w_addr(w_addr),
    .wdata(wdata),
    .new_tag(new_tag),
    .new_valid(new_valid),
    .busy(busy),
    .fill_done(fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tg, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tg, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < WORDS; i++) vm[i] = 1'b0;
    rr = 0;
  endfunction

  function automatic int pick();
    int v;
    for (int i = 0; i < WORDS; i++)
      if (!vm[i]) return i;
    v = rr;
    rr = (rr + 1) % WORDS;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_cycles();
    for (int i = 0; i < WORDS; i++) begin
      step();
      flush = 1'b0;
      @(negedge clk);
      check("fl_wr", 32'(write_), 32'(0));
      check("fl_addr", 32'(w_addr), 32'(i));
      check("fl_nv", 32'(new_valid), 32'(0));
      check("fl_tag", 32'(new_tag), 32'(0));
      check("fl_data", 32'(wdata), 32'(0));
      check("fl_rdy", 32'(miss_ready), 32'(0));
      check("fl_done", 32'(fill_done), 32'(0));
      check("fl_busy", 32'(busy), 32'(1));
    end
    model_clear();
    step();
  endtask

  task automatic idle_flush(input bit with_miss, input logic [7:0] tg);
    flush = 1'b1;
    if (with_miss) begin
      miss_valid = 1'b1;
      miss_tag = tg;
    end
    @(negedge clk);
    check("ifl_rdy", 32'(miss_ready), 32'(0));
    flush_cycles();
  endtask

  task automatic do_fill(input logic [7:0] tg, input logic [7:0] dt,
                         input int dly, input bit fl);
    int exp_a;
    miss_valid = 1'b1;
    miss_tag = tg;
    @(negedge clk);
    check("id_rdy", 32'(miss_ready), 32'(1));
    check("id_wr", 32'(write_), 32'(1));
    check("id_busy", 32'(busy), 32'(0));
    exp_a = pick();
    step();
    miss_valid = 1'b0;
    miss_tag = 8'($urandom);
    if (fl) flush = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("rq_req", 32'(mem_req), 32'(1));
      check("rq_tag", 32'(mem_tag), 32'(tg));
      check("rq_wr", 32'(write_), 32'(1));
      check("rq_busy", 32'(busy), 32'(1));
      step();
      flush = 1'b0;
    end
    mem_ack = 1'b1;
    mem_data = dt;
    @(negedge clk);
    check("ak_req", 32'(mem_req), 32'(1));
    check("ak_tag", 32'(mem_tag), 32'(tg));
    step();
    mem_ack = 1'b0;
    flush = 1'b0;
    mem_data = 8'($urandom);
    @(negedge clk);
    check("wr_wr", 32'(write_), 32'(0));
    check("wr_addr", 32'(w_addr), 32'(exp_a));
    check("wr_tag", 32'(new_tag), 32'(tg));
    check("wr_data", 32'(wdata), 32'(dt));
    check("wr_nv", 32'(new_valid), 32'(1));
    check("wr_done", 32'(fill_done), 32'(1));
    check("wr_req", 32'(mem_req), 32'(0));
    vm[exp_a] = 1'b1;
    step();
    @(negedge clk);
    check("af_wr", 32'(write_), 32'(1));
    check("af_done", 32'(fill_done), 32'(0));
    check("af_req", 32'(mem_req), 32'(0));
    if (fl) begin
      check("af_rdy_pend", 32'(miss_ready), 32'(0));
      flush_cycles();
    end else begin
      check("af_rdy", 32'(miss_ready), 32'(1));
      check("af_busy", 32'(busy), 32'(0));
      step();
    end
  endtask

  task automatic reset_abort(input logic [7:0] tg);
    miss_valid = 1'b1;
    miss_tag = tg;
    @(negedge clk);
    check("ra_rdy", 32'(miss_ready), 32'(1));
    step();
    miss_valid = 1'b0;
    @(negedge clk);
    check("ra_req", 32'(mem_req), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ra_req0", 32'(mem_req), 32'(0));
    check("ra_wr", 32'(write_), 32'(1));
    check("ra_rdy1", 32'(miss_ready), 32'(1));
    check("ra_busy", 32'(busy), 32'(0));
    model_clear();
    mem_ack = 1'b1;
    mem_data = 8'($urandom);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("ra_late_wr", 32'(write_), 32'(1));
    check("ra_late_busy", 32'(busy), 32'(0));
    check("ra_late_done", 32'(fill_done), 32'(0));
    step();
  endtask

  task automatic idle_ack();
    mem_ack = 1'b1;
    mem_data = 8'($urandom);
    @(negedge clk);
    check("ia_wr0", 32'(write_), 32'(1));
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("ia_wr", 32'(write_), 32'(1));
    check("ia_busy", 32'(busy), 32'(0));
    check("ia_req", 32'(mem_req), 32'(0));
    check("ia_rdy", 32'(miss_ready), 32'(1));
    step();
  endtask

  initial begin
    int r;
    rst = 1'b1;
    miss_valid = 1'b0;
    miss_tag = '0;
    mem_ack = 1'b0;
    mem_data = '0;
    flush = 1'b0;
    model_clear();
    step();
    step();
    @(negedge clk);
    check("rs_wr", 32'(write_), 32'(1));
    check("rs_addr", 32'(w_addr), 32'(0));
    check("rs_data", 32'(wdata), 32'(0));
    check("rs_tag", 32'(new_tag), 32'(0));
    check("rs_nv", 32'(new_valid), 32'(0));
    check("rs_req", 32'(mem_req), 32'(0));
    check("rs_mtag", 32'(mem_tag), 32'(0));
    check("rs_busy", 32'(busy), 32'(0));
    check("rs_done", 32'(fill_done), 32'(0));
    check("rs_rdy", 32'(miss_ready), 32'(1));
    step();
    rst = 1'b0;

    do_fill(8'h05, 8'h11, 2, 1'b0);

    idle_flush(1'b0, 8'h00);
    for (int t = 1; t <= 10; t++)
      do_fill(8'(t), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);

    idle_flush(1'b1, 8'h3c);
    do_fill(8'h3c, 8'h5a, 1, 1'b0);

    do_fill(8'h44, 8'h66, 1, 1'b1);
    do_fill(8'h45, 8'h67, 0, 1'b0);

    do_fill(8'h50, 8'h70, 0, 1'b0);
    reset_abort(8'h51);
    do_fill(8'h52, 8'h72, 1, 1'b0);

    do_fill(8'h60, 8'h80, 0, 1'b0);
    idle_ack();

    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)
        do_fill(8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'b0);
      else if (r < 80)
        do_fill(8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'b1);
      else if (r < 88)
        idle_flush(r[0], 8'($urandom));
      else if (r < 94)
        idle_ack();
      else
        reset_abort(8'($urandom));
      miss_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cam_fill_ctrl.md
Name: cam_fill_ctrl

Overview:
Miss-fill controller that owns the write port of the cam block. On a lookup miss it accepts the missing tag and fetches the line from backing memory over a req/ack handshake. It then chooses a victim entry and writes tag, data and valid into the cam in a single write cycle. It also performs a full-cam flush by invalidating every entry in sequence.

Parameters:
BITS, 8, data width of one cam entry
TAG_SZ, 8, tag width
WORDS, 8, number of cam entries; ADDR_LEFT = $clog2(WORDS)-1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; synchronous, active-high
miss_valid  in  1  miss request from the lookup side
miss_tag  in  TAG_SZ  tag that missed
miss_ready  out  1  controller can accept a miss; high only in IDLE with no flush pending or asserted
mem_req  out  1  request to backing memory
mem_tag  out  TAG_SZ  tag being fetched
mem_ack  in  1  memory response valid
mem_data  in  BITS  memory response data
flush  in  1  request to invalidate all entries
write_  out  1  cam write strobe, active-low
w_addr  out  ADDR_LEFT+1  cam write address
wdata  out  BITS  cam write data
new_tag  out  TAG_SZ  cam write tag
new_valid  out  1  cam write valid bit
busy  out  1  high in any state other than IDLE
fill_done  out  1  one-cycle pulse coincident with the fill write

Behaviour:
- States: IDLE, REQ, WRITE, FLUSH. All outputs are registered except miss_ready, which is decoded from the state and the flush inputs.
- Reset: state=IDLE; write_=1; w_addr, wdata, new_tag, new_valid, mem_req, mem_tag, busy, fill_done = 0; local valid map vmap=0; round-robin pointer rr=0; pending-flush flag=0. miss_ready=1 after reset.
- IDLE:
  - If flush is high or a flush is pending, go to FLUSH. Flush wins over a simultaneous miss_valid; the miss is not accepted.
  - Otherwise, if miss_valid && miss_ready: latch miss_tag, latch the victim, go to REQ.
- Victim selection: the lowest-index entry with vmap=0. If every entry is valid, use rr, then increment rr modulo WORDS (wraps WORDS-1 to 0). rr changes only when it is used.
- REQ:
  - mem_req=1 and mem_tag=latched tag from the first cycle after acceptance.
  - mem_req holds until the cycle in which mem_ack=1. mem_data is captured in that cycle, and mem_req drops at the next edge.
  - mem_ack in the same cycle mem_req first rises counts as a valid response.
- WRITE: exactly one cycle with write_=0, w_addr=victim, wdata=captured data, new_tag=latched tag, new_valid=1, fill_done=1. Sets vmap[victim]=1, then returns to IDLE.
- Latency: minimum 2 cycles from miss acceptance edge to the write_ low cycle; in general 1 + mem_ack wait cycles + 1.
- FLUSH:
  - WORDS consecutive cycles with write_=0, new_valid=0, new_tag=0, wdata=0, and w_addr stepping 0..WORDS-1.
  - On exit: vmap=0, rr=0, pending flag cleared, return to IDLE. fill_done stays 0.
- A flush asserted in REQ or WRITE sets the pending flag. The current fill completes normally, then FLUSH runs.
- mem_ack outside REQ is ignored.
- Duplicate tags are not checked; issuing a miss only when cam found_it=0 is the upstream's responsibility.
- rst asserted mid-operation: at the next edge all state returns to reset values; mem_req drops and no write occurs. A mem_ack for the aborted request that arrives later is ignored.
- write_ is never low for two consecutive fill cycles. Between fills it is high for at least 1 cycle (the IDLE cycle).

Test Plan:
1. Reset, then miss_tag=0x05; mem_ack with mem_data=0x11 two cycles after mem_req rises -> one cycle of write_=0 with w_addr=0, new_tag=0x05, wdata=0x11, new_valid=1, fill_done=1; miss_ready returns to 1 the next cycle.
2. Eight fills with tags 0x01..0x08 -> w_addr 0..7. Ninth fill, tag 0x09 -> w_addr=0 (rr). Tenth fill -> w_addr=1.
3. flush and miss_valid high in the same IDLE cycle -> 8 cycles of write_=0, new_valid=0, w_addr 0..7, with miss_ready=0 throughout. The held miss is then accepted and written to w_addr=0.
4. flush pulsed while mem_req=1 -> the fill completes at its victim with fill_done=1, then the 8-cycle flush follows immediately; vmap, checked via the next fill, is cleared and that fill goes to w_addr=0.
5. rst pulsed while mem_req=1 -> the next cycle shows mem_req=0, write_=1, miss_ready=1. A later mem_ack produces no write, and the next fill goes to w_addr=0.
6. mem_ack high in the first mem_req cycle -> write_=0 in the following cycle (2-cycle latency). A mem_ack pulse in IDLE -> no write and no state change.
